// File: rtl/br_resolve_unit.sv
// Pipelined branch/jump resolution for the execute stage: direction, target,
// link and mispredict check behind a valid/ready handshake, with saturating stats.
module br_resolve_unit #(
  parameter int unsigned DATAW = 32,
  parameter int unsigned ADDRW = 32,
  parameter int unsigned SPLIT = 0,
  parameter int unsigned CNTW  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [DATAW-1:0] in_a,
  input  logic [DATAW-1:0] in_b,
  input  logic [ADDRW-1:0] in_pc,
  input  logic [ADDRW-1:0] in_imm,
  input  logic             in_pred_taken,
  input  logic [ADDRW-1:0] in_pred_target,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_taken,
  output logic [ADDRW-1:0] out_target,
  output logic [ADDRW-1:0] out_link,
  output logic             out_mispredict,
  output logic [ADDRW-1:0] out_redirect_pc,
  output logic [CNTW-1:0]  cnt_branch,
  output logic [CNTW-1:0]  cnt_mispredict
);

  typedef enum logic [3:0] {
    OP_EQ   = 4'd0,
    OP_NE   = 4'd1,
    OP_LT   = 4'd4,
    OP_GE   = 4'd5,
    OP_LTU  = 4'd6,
    OP_GEU  = 4'd7,
    OP_JAL  = 4'd8,
    OP_JALR = 4'd9
  } op_e;

  logic [ADDRW-1:0] a_addr, tgt_c, link_c;
  logic             load_out;

  // Final-stage inputs, fed either straight from the ports or from stage 1
  logic [3:0]       f_op;
  logic             f_eq, f_lt, f_ltu, f_pt;
  logic [ADDRW-1:0] f_tgt, f_link, f_ptgt;
  logic             f_valid_op, f_taken, f_mis;
  logic [ADDRW-1:0] f_redir;

  generate
    if (DATAW >= ADDRW) begin : g_a_trunc
      assign a_addr = in_a[ADDRW-1:0];
    end else begin : g_a_ext
      assign a_addr = {{(ADDRW-DATAW){1'b0}}, in_a};
    end
  endgenerate

  assign tgt_c  = (in_op == OP_JALR) ? ((a_addr + in_imm) & ~ADDRW'(1)) : (in_pc + in_imm);
  assign link_c = in_pc + ADDRW'(4);

  always_comb begin
    f_taken    = 1'b0;
    f_valid_op = 1'b1;
    case (f_op)
      OP_EQ:   f_taken = f_eq;
      OP_NE:   f_taken = !f_eq;
      OP_LT:   f_taken = f_lt;
      OP_GE:   f_taken = !f_lt;
      OP_LTU:  f_taken = f_ltu;
      OP_GEU:  f_taken = !f_ltu;
      OP_JAL:  f_taken = 1'b1;
      OP_JALR: f_taken = 1'b1;
      default: f_valid_op = 1'b0;
    endcase
    // Invalid ops resolve not-taken and are never reported as mispredicted
    f_mis   = f_valid_op & ((f_taken != f_pt) | (f_taken & f_pt & (f_tgt != f_ptgt)));
    f_redir = f_taken ? f_tgt : f_link;
  end

  generate
    if (SPLIT == 0) begin : g_single
      assign f_op     = in_op;
      assign f_eq     = (in_a == in_b);
      assign f_lt     = ($signed(in_a) < $signed(in_b));
      assign f_ltu    = (in_a < in_b);
      assign f_tgt    = tgt_c;
      assign f_link   = link_c;
      assign f_pt     = in_pred_taken;
      assign f_ptgt   = in_pred_target;
      assign in_ready = !out_valid | out_ready;
      assign load_out = in_valid & in_ready & !flush;
    end else begin : g_split
      localparam int unsigned HW = DATAW / 2;
      logic             s1_valid, s1_adv, load_s1, eq_hi;
      logic [3:0]       s1_op;
      logic             s1_eq_lo, s1_lt_lo, s1_pt;
      logic [HW-1:0]    s1_a_hi, s1_b_hi;
      logic [ADDRW-1:0] s1_tgt, s1_link, s1_ptgt;

      assign s1_adv   = !out_valid | out_ready;
      assign in_ready = !s1_valid | s1_adv;
      assign load_s1  = in_valid & in_ready & !flush;
      assign load_out = s1_valid & s1_adv & !flush;

      always_ff @(posedge clk) begin
        if (!rst_n)       s1_valid <= 1'b0;
        else if (flush)   s1_valid <= 1'b0;
        else if (load_s1) s1_valid <= 1'b1;
        else if (s1_adv)  s1_valid <= 1'b0;
      end

      always_ff @(posedge clk) begin
        if (load_s1) begin
          s1_op    <= in_op;
          s1_eq_lo <= (in_a[HW-1:0] == in_b[HW-1:0]);
          s1_lt_lo <= (in_a[HW-1:0] <  in_b[HW-1:0]);
          s1_a_hi  <= in_a[DATAW-1:HW];
          s1_b_hi  <= in_b[DATAW-1:HW];
          s1_tgt   <= tgt_c;
          s1_link  <= link_c;
          s1_pt    <= in_pred_taken;
          s1_ptgt  <= in_pred_target;
        end
      end

      // Low halves compare unsigned; only the high halves carry the sign
      assign eq_hi  = (s1_a_hi == s1_b_hi);
      assign f_op   = s1_op;
      assign f_eq   = eq_hi & s1_eq_lo;
      assign f_ltu  = (s1_a_hi < s1_b_hi) | (eq_hi & s1_lt_lo);
      assign f_lt   = ($signed(s1_a_hi) < $signed(s1_b_hi)) | (eq_hi & s1_lt_lo);
      assign f_tgt  = s1_tgt;
      assign f_link = s1_link;
      assign f_pt   = s1_pt;
      assign f_ptgt = s1_ptgt;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid       <= 1'b0;
      out_taken       <= 1'b0;
      out_target      <= '0;
      out_link        <= '0;
      out_mispredict  <= 1'b0;
      out_redirect_pc <= '0;
      cnt_branch      <= '0;
      cnt_mispredict  <= '0;
    end else begin
      if (flush)         out_valid <= 1'b0;
      else if (load_out) out_valid <= 1'b1;
      else if (out_ready) out_valid <= 1'b0;

      if (load_out) begin
        out_taken       <= f_taken;
        out_target      <= f_tgt;
        out_link        <= f_link;
        out_mispredict  <= f_mis;
        out_redirect_pc <= f_redir;
      end

      if (out_valid && out_ready && !flush) begin
        if (cnt_branch != '1) cnt_branch <= cnt_branch + CNTW'(1);
        if (out_mispredict && (cnt_mispredict != '1)) cnt_mispredict <= cnt_mispredict + CNTW'(1);
      end
    end
  end

endmodule

// File: tb/tb_br_resolve_unit.sv
// Directed bench: u0 is the single-stage 32-bit build with 4-bit counters,
// u1 the split 64-bit build.
module tb_br_resolve_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic        fl0, v0, pt0, ordy0, rdy0, ov0, otk0, omis0;
  logic [3:0]  op0;
  logic [31:0] a0, b0, pc0, imm0, ptg0, otg0, olk0, ordr0;
  logic [3:0]  cb0, cm0;

  logic        fl1, v1, pt1, ordy1, rdy1, ov1, otk1, omis1;
  logic [3:0]  op1;
  logic [63:0] a1, b1;
  logic [31:0] pc1, imm1, ptg1, otg1, olk1, ordr1;
  logic [15:0] cb1, cm1;

  br_resolve_unit #(.DATAW(32), .ADDRW(32), .SPLIT(0), .CNTW(4)) u0 (
    .clk(clk), .rst_n(rst_n), .flush(fl0), .in_valid(v0), .in_ready(rdy0),
    .in_op(op0), .in_a(a0), .in_b(b0), .in_pc(pc0), .in_imm(imm0),
    .in_pred_taken(pt0), .in_pred_target(ptg0), .out_valid(ov0), .out_ready(ordy0),
    .out_taken(otk0), .out_target(otg0), .out_link(olk0), .out_mispredict(omis0),
    .out_redirect_pc(ordr0), .cnt_branch(cb0), .cnt_mispredict(cm0));

  br_resolve_unit #(.DATAW(64), .ADDRW(32), .SPLIT(1), .CNTW(16)) u1 (
    .clk(clk), .rst_n(rst_n), .flush(fl1), .in_valid(v1), .in_ready(rdy1),
    .in_op(op1), .in_a(a1), .in_b(b1), .in_pc(pc1), .in_imm(imm1),
    .in_pred_taken(pt1), .in_pred_target(ptg1), .out_valid(ov1), .out_ready(ordy1),
    .out_taken(otk1), .out_target(otg1), .out_link(olk1), .out_mispredict(omis1),
    .out_redirect_pc(ordr1), .cnt_branch(cb1), .cnt_mispredict(cm1));

  function automatic logic ref_take(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    case (op)
      4'd0: ref_take = (a == b);
      4'd1: ref_take = (a != b);
      4'd4: ref_take = ($signed(a) < $signed(b));
      4'd5: ref_take = !($signed(a) < $signed(b));
      4'd6: ref_take = (a < b);
      4'd7: ref_take = !(a < b);
      default: ref_take = 1'b0;
    endcase
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; v0 = 1'b0; v1 = 1'b0; fl0 = 1'b0; fl1 = 1'b0;
    ordy0 = 1'b1; ordy1 = 1'b1;
    step; step;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    step; step;
    total++; if ({ov0, otk0, omis0, otg0, olk0, ordr0, cb0, cm0} !== '0) begin bad++;
      $display("FAIL reset_u0 got=%h exp=0", {ov0, otk0, omis0, otg0, olk0, ordr0, cb0, cm0}); end
    total++; if ({ov1, otk1, omis1, otg1, olk1, ordr1, cb1, cm1} !== '0) begin bad++;
      $display("FAIL reset_u1 got=%h exp=0", {ov1, otk1, omis1, otg1, olk1, ordr1, cb1, cm1}); end
    total++; if ({rdy0, rdy1} !== 2'b11) begin bad++;
      $display("FAIL reset_ready got=%b exp=11", {rdy0, rdy1}); end
    rst_n = 1'b1;
    step;
    total++; if ({rdy0, rdy1, ov0, ov1} !== 4'b1100) begin bad++;
      $display("FAIL post_reset got=%b exp=1100", {rdy0, rdy1, ov0, ov1}); end
  endtask

  task automatic test_blt;
    ordy0 = 1'b1; v0 = 1'b1; op0 = 4'd4; a0 = 32'hFFFFFFFF; b0 = 32'd1;
    pc0 = 32'h100; imm0 = 32'h20; pt0 = 1'b0; ptg0 = 32'h0;
    step;
    total++; if ({ov0, otk0, omis0} !== 3'b111) begin bad++;
      $display("FAIL blt_flags got=%b exp=111", {ov0, otk0, omis0}); end
    total++; if ({otg0, ordr0, olk0} !== {32'h120, 32'h120, 32'h104}) begin bad++;
      $display("FAIL blt_addr got=%h %h %h exp=120 120 104", otg0, ordr0, olk0); end
    op0 = 4'd6;
    step;
    total++; if ({ov0, otk0, omis0} !== 3'b100) begin bad++;
      $display("FAIL bltu_flags got=%b exp=100", {ov0, otk0, omis0}); end
    total++; if ({otg0, ordr0} !== {32'h120, 32'h104}) begin bad++;
      $display("FAIL bltu_addr got=%h %h exp=120 104", otg0, ordr0); end
    v0 = 1'b0;
    step;
    total++; if ({ov0, otg0, ordr0} !== {1'b0, 32'h120, 32'h104}) begin bad++;
      $display("FAIL idle_hold got=%b %h %h exp=0 120 104", ov0, otg0, ordr0); end
    total++; if ({cb0, cm0} !== {4'd2, 4'd1}) begin bad++;
      $display("FAIL blt_counts got=%0d %0d exp=2 1", cb0, cm0); end
  endtask

  task automatic test_jalr;
    v0 = 1'b1; op0 = 4'd9; a0 = 32'h1003; b0 = 32'h0; imm0 = 32'h4;
    pc0 = 32'h200; pt0 = 1'b1; ptg0 = 32'h1006;
    step;
    total++; if ({ov0, otk0, omis0} !== 3'b110) begin bad++;
      $display("FAIL jalr_flags got=%b exp=110", {ov0, otk0, omis0}); end
    total++; if ({otg0, olk0, ordr0} !== {32'h1006, 32'h204, 32'h1006}) begin bad++;
      $display("FAIL jalr_addr got=%h %h %h exp=1006 204 1006", otg0, olk0, ordr0); end
    ptg0 = 32'h1008;
    step;
    total++; if ({otk0, omis0, ordr0} !== {2'b11, 32'h1006}) begin bad++;
      $display("FAIL jalr_badtgt got=%b %b %h exp=1 1 1006", otk0, omis0, ordr0); end
    op0 = 4'd8; pc0 = 32'hFFFFFFF0; imm0 = 32'h20; ptg0 = 32'h10; pt0 = 1'b1;
    step;
    total++; if ({otk0, omis0, otg0, olk0} !== {2'b10, 32'h10, 32'hFFFFFFF4}) begin bad++;
      $display("FAIL jal_wrap got=%b %b %h %h exp=1 0 10 fffffff4", otk0, omis0, otg0, olk0); end
    op0 = 4'd9; a0 = 32'h5; imm0 = 32'hFFFFFFFF; pc0 = 32'hFFFFFFFC; pt0 = 1'b0;
    step;
    total++; if ({otk0, omis0, otg0, olk0, ordr0} !== {2'b11, 32'h4, 32'h0, 32'h4}) begin bad++;
      $display("FAIL jalr_neg got=%b %b %h %h %h exp=1 1 4 0 4", otk0, omis0, otg0, olk0, ordr0); end
    v0 = 1'b0;
    step;
  endtask

  task automatic test_invalid;
    do_reset;
    v0 = 1'b1; op0 = 4'd3; a0 = 32'h0; b0 = 32'h0; pc0 = 32'h300; imm0 = 32'h10;
    pt0 = 1'b1; ptg0 = 32'h310;
    step;
    total++; if ({ov0, otk0, omis0} !== 3'b100) begin bad++;
      $display("FAIL inv_flags got=%b exp=100", {ov0, otk0, omis0}); end
    total++; if ({otg0, ordr0} !== {32'h310, 32'h304}) begin bad++;
      $display("FAIL inv_addr got=%h %h exp=310 304", otg0, ordr0); end
    v0 = 1'b0;
    step;
    total++; if ({cb0, cm0} !== {4'd1, 4'd0}) begin bad++;
      $display("FAIL inv_counts got=%0d %0d exp=1 0", cb0, cm0); end
  endtask

  task automatic test_backpressure;
    do_reset;
    ordy1 = 1'b0;
    v1 = 1'b1; op1 = 4'd0; a1 = 64'h12345678_9ABCDEF0; b1 = 64'h12345678_9ABCDEF0;
    pc1 = 32'h1000; imm1 = 32'h40; pt1 = 1'b1; ptg1 = 32'h1040;
    step;
    op1 = 4'd5; a1 = 64'h80000000_00000000; b1 = 64'h0; pc1 = 32'h2000; ptg1 = 32'h2040;
    total++; if (rdy1 !== 1'b1) begin bad++; $display("FAIL bp_accept_b got=%b exp=1", rdy1); end
    step;
    op1 = 4'd7; pc1 = 32'h3000; imm1 = 32'hFFFFFFF8; pt1 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      total++; if (rdy1 !== 1'b0) begin bad++; $display("FAIL bp_ready got=%b exp=0", rdy1); end
      total++; if ({ov1, otk1, omis1, otg1, olk1, ordr1, cb1} !== {3'b110, 32'h1040, 32'h1004, 32'h1040, 16'd0}) begin bad++;
        $display("FAIL bp_hold got=%b%b%b %h %h %h %0d exp=110 1040 1004 1040 0", ov1, otk1, omis1, otg1, olk1, ordr1, cb1); end
      step;
    end
    ordy1 = 1'b1;
    #1;
    total++; if (rdy1 !== 1'b1) begin bad++; $display("FAIL bp_release got=%b exp=1", rdy1); end
    step;
    total++; if ({ov1, otk1, omis1, otg1, ordr1, cb1, cm1} !== {3'b101, 32'h2040, 32'h2004, 16'd1, 16'd0}) begin bad++;
      $display("FAIL bp_b got=%b%b%b %h %h %0d %0d exp=101 2040 2004 1 0", ov1, otk1, omis1, otg1, ordr1, cb1, cm1); end
    v1 = 1'b0;
    step;
    total++; if ({ov1, otk1, omis1, otg1, ordr1, cb1, cm1} !== {3'b111, 32'h2FF8, 32'h2FF8, 16'd2, 16'd1}) begin bad++;
      $display("FAIL bp_c got=%b%b%b %h %h %0d %0d exp=111 2ff8 2ff8 2 1", ov1, otk1, omis1, otg1, ordr1, cb1, cm1); end
    step;
    total++; if ({ov1, cb1, cm1} !== {1'b0, 16'd3, 16'd2}) begin bad++;
      $display("FAIL bp_drain got=%b %0d %0d exp=0 3 2", ov1, cb1, cm1); end
    step;
    total++; if ({ov1, cb1} !== {1'b0, 16'd3}) begin bad++;
      $display("FAIL bp_nodup got=%b %0d exp=0 3", ov1, cb1); end
  endtask

  task automatic test_split_sweep;
    logic [63:0] ta [8];
    logic [63:0] tb [8];
    logic [3:0]  ops [6];
    logic        e;
    ta[0] = 64'h0;                   tb[0] = 64'h0;
    ta[1] = 64'h00000001_80000000;   tb[1] = 64'h00000001_00000000;
    ta[2] = 64'h00000001_00000000;   tb[2] = 64'h00000001_80000000;
    ta[3] = 64'h80000000_00000000;   tb[3] = 64'h7FFFFFFF_FFFFFFFF;
    ta[4] = 64'hFFFFFFFF_FFFFFFFF;   tb[4] = 64'h00000000_00000001;
    ta[5] = 64'hFFFFFFFF_00000000;   tb[5] = 64'hFFFFFFFF_00000001;
    ta[6] = 64'h00000002_00000000;   tb[6] = 64'h00000001_FFFFFFFF;
    ta[7] = 64'h7FFFFFFF_FFFFFFFF;   tb[7] = 64'h7FFFFFFF_FFFFFFFF;
    ops[0] = 4'd0; ops[1] = 4'd1; ops[2] = 4'd4; ops[3] = 4'd5; ops[4] = 4'd6; ops[5] = 4'd7;
    do_reset;
    pc1 = 32'h400; imm1 = 32'h10; pt1 = 1'b0; ptg1 = 32'h0;
    for (int p = 0; p < 8; p++) begin
      for (int o = 0; o < 6; o++) begin
        v1 = 1'b1; op1 = ops[o]; a1 = ta[p]; b1 = tb[p];
        e = ref_take(ops[o], ta[p], tb[p]);
        step;
        v1 = 1'b0;
        total++; if (ov1 !== 1'b0) begin bad++;
          $display("FAIL split_latency pair=%0d op=%0d got=%b exp=0", p, ops[o], ov1); end
        step;
        total++; if ({ov1, otk1, omis1, ordr1} !== {1'b1, e, e, (e ? 32'h410 : 32'h404)}) begin bad++;
          $display("FAIL split_cmp pair=%0d op=%0d got=%b%b%b %h exp=1%b%b", p, ops[o], ov1, otk1, omis1, ordr1, e, e); end
      end
    end
    step;
  endtask

  task automatic test_back_to_back;
    int k;
    do_reset;
    k = 0;
    op1 = 4'd8; imm1 = 32'h0; pt1 = 1'b1; a1 = 64'h0; b1 = 64'h0;
    for (int c = 0; c <= 100; c++) begin
      if (c < 100) begin
        v1 = 1'b1; pc1 = 32'h1000 + 32'(c * 8); ptg1 = pc1;
        total++; if (rdy1 !== 1'b1) begin bad++; $display("FAIL b2b_ready cycle=%0d got=%b exp=1", c, rdy1); end
      end else begin
        v1 = 1'b0;
      end
      step;
      if (ov1 === 1'b1) begin
        total++; if ({olk1, omis1} !== {32'h1000 + 32'(k * 8) + 32'd4, 1'b0}) begin bad++;
          $display("FAIL b2b_order idx=%0d got=%h %b exp=%h 0", k, olk1, omis1, 32'h1000 + 32'(k * 8) + 32'd4); end
        k++;
      end
    end
    total++; if (k !== 100) begin bad++; $display("FAIL b2b_count got=%0d exp=100", k); end
    step;
    total++; if ({ov1, cb1, cm1} !== {1'b0, 16'd100, 16'd0}) begin bad++;
      $display("FAIL b2b_cnt got=%b %0d %0d exp=0 100 0", ov1, cb1, cm1); end
  endtask

  task automatic test_flush;
    do_reset;
    op1 = 4'd8; imm1 = 32'h0; pt1 = 1'b1;
    v1 = 1'b1; pc1 = 32'h500; ptg1 = 32'h500;
    step;
    pc1 = 32'h600; ptg1 = 32'h600;
    step;
    pc1 = 32'h700; ptg1 = 32'h700; fl1 = 1'b1;
    #1;
    total++; if ({rdy1, ov1, olk1} !== {2'b11, 32'h504}) begin bad++;
      $display("FAIL flush_pre got=%b %b %h exp=1 1 504", rdy1, ov1, olk1); end
    step;
    total++; if ({ov1, cb1, cm1, olk1} !== {1'b0, 16'd0, 16'd0, 32'h504}) begin bad++;
      $display("FAIL flush_clear got=%b %0d %0d %h exp=0 0 0 504", ov1, cb1, cm1, olk1); end
    fl1 = 1'b0; v1 = 1'b0;
    step; step; step;
    total++; if ({ov1, cb1, cm1} !== {1'b0, 16'd0, 16'd0}) begin bad++;
      $display("FAIL flush_after got=%b %0d %0d exp=0 0 0", ov1, cb1, cm1); end
  endtask

  task automatic test_reset_mid;
    do_reset;
    op1 = 4'd8; imm1 = 32'h0; pt1 = 1'b1; v1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pc1 = 32'h800 + 32'(i * 4); ptg1 = pc1;
      step;
    end
    total++; if ({ov1, cb1} !== {1'b1, 16'd2}) begin bad++;
      $display("FAIL rmid_pre got=%b %0d exp=1 2", ov1, cb1); end
    rst_n = 1'b0;
    step;
    total++; if ({ov1, otk1, omis1, otg1, olk1, ordr1, cb1, cm1} !== '0) begin bad++;
      $display("FAIL rmid_zero got=%h exp=0", {ov1, otk1, omis1, otg1, olk1, ordr1, cb1, cm1}); end
    total++; if (rdy1 !== 1'b1) begin bad++; $display("FAIL rmid_ready got=%b exp=1", rdy1); end
    rst_n = 1'b1; v1 = 1'b0;
    step;
  endtask

  task automatic test_saturation;
    do_reset;
    v0 = 1'b1; op0 = 4'd0; a0 = 32'h5; b0 = 32'h5; pc0 = 32'h100; imm0 = 32'h8;
    pt0 = 1'b0; ptg0 = 32'h0;
    for (int i = 0; i < 20; i++) step;
    v0 = 1'b0;
    step; step;
    total++; if ({cb0, cm0} !== {4'd15, 4'd15}) begin bad++;
      $display("FAIL saturate got=%0d %0d exp=15 15", cb0, cm0); end
  endtask

  initial begin
    fl0 = 1'b0; v0 = 1'b0; pt0 = 1'b0; ordy0 = 1'b1; op0 = 4'd0;
    a0 = '0; b0 = '0; pc0 = '0; imm0 = '0; ptg0 = '0;
    fl1 = 1'b0; v1 = 1'b0; pt1 = 1'b0; ordy1 = 1'b1; op1 = 4'd0;
    a1 = '0; b1 = '0; pc1 = '0; imm1 = '0; ptg1 = '0;
    test_reset;
    test_blt;
    test_jalr;
    test_invalid;
    test_backpressure;
    test_split_sweep;
    test_back_to_back;
    test_flush;
    test_reset_mid;
    test_saturation;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
